// File: rtl/result_drain.sv
// Sequences one job on the systolic control block, snapshots its N*N result and
// streams the elements out in ascending index over a valid/ready interface.
module result_drain #(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int SETTLE = 2,
    localparam int IW    = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_done,
    input  logic [W*N*N-1:0] i_C,
    output logic             o_ctrl_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_data,
    output logic [IW-1:0]    o_idx,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_job_done
);

    localparam int NE = N * N;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SettleLoad = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
    localparam logic [IW-1:0] LastIdx    = IW'(NE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWait, StDrain} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_buf [NE];
    logic [IW-1:0]   r_idx;
    logic            r_job_done;
    logic            w_capture;
    logic            w_accept;
    logic            w_last_accept;

    assign w_accept      = (r_state == StDrain) && i_ready;
    assign w_last_accept = w_accept && (r_idx == LastIdx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (i_done) begin
                    if (SETTLE == 0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = StDrain;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_last_accept) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Loaded with SETTLE-1 so that WAIT spans exactly SETTLE cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == StRun) && i_done) begin
            r_cnt <= SettleLoad;
        end else if ((r_state == StWait) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NE; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < NE; k++) begin
                r_buf[k] <= i_C[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_job_done <= 1'b0;
        end else begin
            r_job_done <= w_last_accept;
            if (w_accept) begin
                r_idx <= w_last_accept ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign o_ctrl_en  = (r_state == StRun) || (r_state == StWait);
    assign o_valid    = (r_state == StDrain);
    assign o_busy     = (r_state != StIdle);
    assign o_last     = o_valid && (r_idx == LastIdx);
    assign o_idx      = r_idx;
    // Outside DRAIN the data bus is forced to zero rather than exposing stale results.
    assign o_data     = o_valid ? r_buf[r_idx] : '0;
    assign o_job_done = r_job_done;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: a job table plus hand-written reset sequences, with the
// expected stream kept as a queue of the snapshotted elements.
module tb_result_drain;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int S  = 2;
    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam int CW = W * NE;

    typedef struct {
        logic [CW-1:0] cv;
        int            done_delay;
        int            rdy_mode;
        bit            noise;
        bit            hold_start;
        bit            pre_started;
        int            exp_lat;
        int            exp_beats;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          done;
    logic          ready;
    logic [CW-1:0] c;
    logic          ctrl_en;
    logic          valid;
    logic          last;
    logic          busy;
    logic          job_done;
    logic [W-1:0]  data;
    logic [IW-1:0] idx;

    int   total = 0;
    int   bad   = 0;
    bit   rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vec_t vecs [6];

    always #5 clk = ~clk;

    result_drain #(
        .W      (W),
        .N      (N),
        .SETTLE (S)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_done     (done),
        .i_C        (c),
        .o_ctrl_en  (ctrl_en),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_data     (data),
        .o_idx      (idx),
        .o_last     (last),
        .o_busy     (busy),
        .o_job_done (job_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 64'({ctrl_en, valid, last, busy, job_done, idx, data}), 64'd0);
    endtask

    function automatic logic [CW-1:0] rand_c();
        logic [CW-1:0] r;
        for (int k = 0; k < NE; k++) begin
            r[k*W +: W] = W'($urandom);
        end
        return r;
    endfunction

    task automatic run_job(input vec_t v);
        logic [W-1:0] q [$];
        int beats;
        int cyc;
        if (!v.pre_started) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = v.hold_start;
            @(negedge clk);
            chk("start_ctrl_en", 64'(ctrl_en), 64'd1);
            chk("start_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end else begin
            start = v.hold_start;
        end
        repeat (v.done_delay) begin
            if (v.noise) start = 1'($urandom);
            c = rand_c();
            @(posedge clk); #1;
        end
        done = 1'b1;
        c = (v.exp_lat == 1) ? v.cv : rand_c();
        @(posedge clk); #1;
        done = 1'b0;
        // i_C only carries the real result in the cycle just before the expected capture edge
        for (int k = 0; k < v.exp_lat - 1; k++) begin
            c = (k == v.exp_lat - 2) ? v.cv : rand_c();
            if (v.noise) start = 1'($urandom);
            @(negedge clk);
            chk("settle_valid", 64'(valid), 64'd0);
            chk("settle_ctrl_en", 64'(ctrl_en), 64'd1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < NE; k++) begin
            q.push_back(v.cv[k*W +: W]);
        end
        c = '1;
        beats = 0;
        cyc = 0;
        while (beats < NE && cyc < 200) begin
            case (v.rdy_mode)
                0:       ready = 1'b1;
                1:       ready = rdy_pat[cyc % 4];
                default: ready = (cyc > 40) ? 1'b1 : 1'($urandom);
            endcase
            if (v.noise) begin
                start = 1'($urandom);
                done  = 1'($urandom);
            end else begin
                start = v.hold_start;
            end
            @(negedge clk);
            chk("drain_valid", 64'(valid), 64'd1);
            chk("drain_ctrl_en", 64'(ctrl_en), 64'd0);
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_data", 64'(data), 64'(q[0]));
            chk("drain_idx", 64'(idx), 64'(beats));
            chk("drain_last", 64'(last), 64'(beats == NE - 1));
            chk("drain_job_done", 64'(job_done), 64'd0);
            if (ready) begin
                void'(q.pop_front());
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = v.hold_start;
        done  = 1'b0;
        ready = 1'b0;
        chk("beat_count", 64'(beats), 64'(v.exp_beats));
        @(negedge clk);
        chk("end_valid", 64'(valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_job_done", 64'(job_done), 64'd1);
        chk("end_ctrl_en", 64'(ctrl_en), 64'd0);
        chk("end_last", 64'(last), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("job_done_pulse", 64'(job_done), 64'd0);
        if (v.hold_start) begin
            chk("b2b_busy", 64'(busy), 64'd1);
            chk("b2b_ctrl_en", 64'(ctrl_en), 64'd1);
        end else begin
            chk("no_requeue", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] tmp;
        int n;

        for (int i = 0; i < 6; i++) begin
            vecs[i] = '{cv: rand_c(), done_delay: 0, rdy_mode: 0, noise: 1'b0,
                        hold_start: 1'b0, pre_started: 1'b0, exp_lat: S + 1, exp_beats: NE};
        end
        for (int k = 0; k < NE; k++) tmp[k*W +: W] = W'(k + 1);
        vecs[0].cv = tmp;
        vecs[0].done_delay = 3;
        vecs[1].rdy_mode = 1;
        vecs[2].done_delay = 5;
        vecs[2].rdy_mode = 2;
        vecs[2].noise = 1'b1;
        for (int k = 0; k < NE; k++) tmp[k*W +: W] = W'(k * 16'h1111);
        vecs[3].cv = tmp;
        vecs[3].done_delay = 1;
        vecs[3].hold_start = 1'b1;
        vecs[4].done_delay = 2;
        vecs[4].rdy_mode = 1;
        vecs[4].pre_started = 1'b1;
        for (int k = 0; k < NE; k++) tmp[k*W +: W] = W'(16'h8000 | k);
        vecs[5].cv = tmp;
        vecs[5].rdy_mode = 2;
        vecs[5].noise = 1'b1;

        rst_n = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        ready = 1'b0;
        c     = '0;
        #12;
        chk_zero("reset_values");
        @(posedge clk); #1 rst_n = 1'b1;

        // i_done in IDLE must not start anything
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", 64'(busy), 64'd0);
        chk("idle_done_ctrl_en", 64'(ctrl_en), 64'd0);

        // asynchronous reset while in RUN
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_in_run");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_valid", 64'(valid), 64'd0);

        // asynchronous reset mid-DRAIN discards the job
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done = 1'b1;
        c = rand_c();
        @(posedge clk); #1 done = 1'b0;
        ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_reached", 64'(valid), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("reset_in_drain");
        @(posedge clk); #1 rst_n = 1'b1;
        ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_done_after_reset", 64'({job_done, valid}), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
